// File: rtl/dec_bpv_seq_if.sv
// Handshake bundle for the BPV sequential decoder: descriptor in, decoded BPVs out.
interface dec_bpv_seq_if #(
  parameter int NUM_PART     = 4,
  parameter int BPV_NUM_BITS = 6,
  parameter int SUFFIX_W     = 128
);
  logic                               in_valid;
  logic                               in_ready;
  logic                               mode_BP;
  logic [NUM_PART-1:0]                use2x2;
  logic [SUFFIX_W-1:0]                suffix;
  logic                               out_valid;
  logic                               out_ready;
  logic [2*NUM_PART*BPV_NUM_BITS-1:0] bpv_vec;
  logic [7:0]                         bpv_size;
  logic [SUFFIX_W-1:0]                suffix_rem;

  modport slave (
    input  in_valid, mode_BP, use2x2, suffix, out_ready,
    output in_ready, out_valid, bpv_vec, bpv_size, suffix_rem
  );

  modport master (
    output in_valid, mode_BP, use2x2, suffix, out_ready,
    input  in_ready, out_valid, bpv_vec, bpv_size, suffix_rem
  );
endinterface

// File: rtl/dec_bpv_seq.sv
// Sequential BPV decoder: one partition per cycle, MSB-first from a left-aligned suffix.
// The suffix register is shifted as fields are consumed, so its top bits are always the cursor.
module dec_bpv_part #(
  parameter int B            = 5,
  parameter int BPV_NUM_BITS = 6,
  parameter int IS_FLS       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    shared,
  input  logic [B-1:0]            v0,
  input  logic [B-1:0]            v1,
  output logic [BPV_NUM_BITS-1:0] slot0,
  output logic [BPV_NUM_BITS-1:0] slot1
);
  logic [BPV_NUM_BITS-1:0] e0, e1;

  // FLS offset 2^b lands exactly on the extra top bit of the slot
  if (IS_FLS != 0) begin : g_fls
    assign e0 = {1'b1, v0};
    assign e1 = {1'b1, v1};
  end else begin : g_raw
    assign e0 = v0;
    assign e1 = v1;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      slot0 <= '0;
      slot1 <= '0;
    end else if (en) begin
      slot0 <= e0;
      slot1 <= shared ? e0 : e1;
    end
  end
endmodule

module dec_bpv_seq #(
  parameter int NUM_PART     = 4,
  parameter int BPV_NUM_BITS = 6,
  parameter int IS_FLS       = 1,
  parameter int SUFFIX_W     = 128
) (
  input logic          clk,
  input logic          rst,
  dec_bpv_seq_if.slave bus
);
  localparam int B  = (IS_FLS != 0) ? BPV_NUM_BITS - 1 : BPV_NUM_BITS;
  localparam int PW = (NUM_PART > 1) ? $clog2(NUM_PART) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_PART - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PARSE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]          state;
  logic [PW-1:0]       pidx;
  logic [7:0]          cursor;
  logic [SUFFIX_W-1:0] sfx;
  logic [NUM_PART-1:0] use_r;
  logic                out_valid_r;
  logic                accept;
  logic [NUM_PART-1:0] part_sel;
  logic                shared;
  logic [B-1:0]        v0, v1;
  logic [7:0]          step;
  logic [2*NUM_PART-1:0][BPV_NUM_BITS-1:0] slots;

  assign accept = (state == S_IDLE) && bus.in_valid;
  assign v0     = sfx[SUFFIX_W-1 -: B];
  assign v1     = sfx[SUFFIX_W-1-B -: B];
  assign shared = |(use_r & part_sel);
  assign step   = shared ? 8'(B) : 8'(2 * B);

  for (genvar k = 0; k < NUM_PART; k++) begin : g_part
    assign part_sel[k] = (pidx == PW'(k));
    dec_bpv_part #(
      .B(B), .BPV_NUM_BITS(BPV_NUM_BITS), .IS_FLS(IS_FLS)
    ) u_part (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .en    ((state == S_PARSE) && part_sel[k]),
      .shared(use_r[k]),
      .v0    (v0),
      .v1    (v1),
      .slot0 (slots[2*k]),
      .slot1 (slots[2*k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      pidx        <= '0;
      cursor      <= '0;
      sfx         <= '0;
      use_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          use_r       <= bus.use2x2;
          sfx         <= bus.suffix;
          cursor      <= '0;
          pidx        <= '0;
          state       <= bus.mode_BP ? S_PARSE : S_DONE;
          out_valid_r <= !bus.mode_BP;
        end
        S_PARSE: begin
          sfx    <= sfx << step;
          cursor <= cursor + step;
          if (pidx == LAST) begin
            pidx        <= '0;
            state       <= S_DONE;
            out_valid_r <= 1'b1;
          end else begin
            pidx <= pidx + 1'b1;
          end
        end
        S_DONE: if (bus.out_ready) begin
          state       <= S_IDLE;
          out_valid_r <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == S_IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.bpv_vec    = slots;
  assign bus.bpv_size   = cursor;
  assign bus.suffix_rem = sfx;
endmodule

// File: tb/tb_dec_bpv_seq.sv
// Directed bench for dec_bpv_seq: scoreboard queue of expected results, checked on out_valid.
module tb_dec_bpv_seq;
  localparam int NP  = 4;
  localparam int W   = 6;
  localparam int FLS = 1;
  localparam int SW  = 128;
  localparam int B   = (FLS != 0) ? W - 1 : W;

  typedef struct packed {
    logic [2*NP*W-1:0] vec;
    logic [7:0]        size;
    logic [SW-1:0]     rem;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  dec_bpv_seq_if #(.NUM_PART(NP), .BPV_NUM_BITS(W), .SUFFIX_W(SW)) bus ();

  dec_bpv_seq #(
    .NUM_PART(NP), .BPV_NUM_BITS(W), .IS_FLS(FLS), .SUFFIX_W(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] rnd_sfx();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic exp_t model(input logic m, input logic [NP-1:0] u, input logic [SW-1:0] s);
    exp_t e;
    int cur;
    logic [SW-1:0] t;
    logic [B-1:0] a, c;
    e.vec = '0;
    cur = 0;
    if (m) begin
      for (int p = 0; p < NP; p++) begin
        t = s << cur; a = t[SW-1 -: B]; cur += B;
        if (u[p]) c = a;
        else begin t = s << cur; c = t[SW-1 -: B]; cur += B; end
        e.vec[(2*p)*W +: W]   = W'(a) + W'((FLS != 0) ? (1 << B) : 0);
        e.vec[(2*p+1)*W +: W] = W'(c) + W'((FLS != 0) ? (1 << B) : 0);
      end
    end
    e.size = 8'(cur);
    e.rem  = s << cur;
    return e;
  endfunction

  task automatic send(input logic m, input logic [NP-1:0] u, input logic [SW-1:0] s, output int t_acc);
    int n;
    bus.in_valid = 1'b1; bus.mode_BP = m; bus.use2x2 = u; bus.suffix = s;
    n = 0;
    while (!bus.in_ready && n < 50) begin step(); n++; end
    chk("accept_timeout", 256'(n < 50), 256'(1));
    step();
    t_acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input int t_acc, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!bus.out_valid && n < 50) begin step(); n++; end
    chk("out_timeout", 256'(n < 50), 256'(1));
    chk("latency", 256'(cyc + 1 - t_acc), 256'(lat));
    chk("sb_nonempty", 256'(exp_q.size() > 0), 256'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("bpv_vec", 256'(bus.bpv_vec), 256'(e.vec));
      chk("bpv_size", 256'(bus.bpv_size), 256'(e.size));
      chk("suffix_rem", 256'(bus.suffix_rem), 256'(e.rem));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("out_valid_clear", 256'(bus.out_valid), 256'(0));
  endtask

  initial begin
    int t, t2, last, nacc;
    logic [SW-1:0] s;
    logic [NP-1:0] u;
    exp_t e;

    bus.in_valid = 1'b0; bus.mode_BP = 1'b0; bus.use2x2 = '0;
    bus.suffix = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_bpv_vec", 256'(bus.bpv_vec), 256'(0));
    chk("rst_bpv_size", 256'(bus.bpv_size), 256'(0));
    chk("rst_suffix_rem", 256'(bus.suffix_rem), 256'(0));

    // all partitions shared
    s = rnd_sfx(); s[127:108] = 20'b00001_00010_00011_00100;
    e.vec = {6'd36, 6'd36, 6'd35, 6'd35, 6'd34, 6'd34, 6'd33, 6'd33};
    e.size = 8'd20; e.rem = s << 20;
    exp_q.push_back(e);
    send(1'b1, 4'b1111, s, t); recv(t, NP + 1);

    // all partitions split, all-ones fields
    s = rnd_sfx(); s[127:88] = '1;
    e.vec = {8{6'd63}}; e.size = 8'd40; e.rem = {s[87:0], 40'd0};
    exp_q.push_back(e);
    send(1'b1, 4'b0000, s, t); recv(t, NP + 1);

    // mixed shared/split
    s = rnd_sfx(); s[127:98] = 30'b00000_00001_00010_00011_00100_00101;
    e.vec = {6'd37, 6'd36, 6'd35, 6'd35, 6'd34, 6'd33, 6'd32, 6'd32};
    e.size = 8'd30; e.rem = s << 30;
    exp_q.push_back(e);
    send(1'b1, 4'b0101, s, t); recv(t, NP + 1);

    // non-BP passthrough
    s = {16{8'hA5}};
    e.vec = '0; e.size = 8'd0; e.rem = s;
    exp_q.push_back(e);
    send(1'b0, 4'b1010, s, t); recv(t, 1);

    // backpressure in DONE with a second block waiting
    s = rnd_sfx();
    e = model(1'b1, 4'b0011, s);
    send(1'b1, 4'b0011, s, t);
    t2 = 0;
    while (!bus.out_valid && t2 < 50) begin step(); t2++; end
    chk("bp_out_timeout", 256'(t2 < 50), 256'(1));
    s = rnd_sfx(); u = 4'b1001;
    bus.in_valid = 1'b1; bus.mode_BP = 1'b1; bus.use2x2 = u; bus.suffix = s;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 256'(bus.out_valid), 256'(1));
      chk("bp_hold_in_ready", 256'(bus.in_ready), 256'(0));
      chk("bp_hold_vec", 256'(bus.bpv_vec), 256'(e.vec));
      chk("bp_hold_size", 256'(bus.bpv_size), 256'(e.size));
      chk("bp_hold_rem", 256'(bus.suffix_rem), 256'(e.rem));
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 256'(bus.out_valid), 256'(0));
    chk("bp_release_in_ready", 256'(bus.in_ready), 256'(1));
    step();
    t2 = cyc;
    bus.in_valid = 1'b0;
    chk("bp_second_accepted", 256'(bus.in_ready), 256'(0));
    exp_q.push_back(model(1'b1, u, s));
    recv(t2, NP + 1);

    // reset while partition 2 would be parsed; block is dropped
    s = rnd_sfx();
    send(1'b1, 4'b0110, s, t);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("midrst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("midrst_vec", 256'(bus.bpv_vec), 256'(0));
    chk("midrst_size", 256'(bus.bpv_size), 256'(0));
    chk("midrst_rem", 256'(bus.suffix_rem), 256'(0));
    s = rnd_sfx();
    exp_q.push_back(model(1'b1, 4'b0110, s));
    send(1'b1, 4'b0110, s, t); recv(t, NP + 1);

    // random blocks
    for (int i = 0; i < 6; i++) begin
      s = rnd_sfx(); u = NP'($urandom);
      exp_q.push_back(model(i != 3, u, s));
      send(i != 3, u, s, t); recv(t, (i != 3) ? NP + 1 : 1);
    end

    // throughput with out_ready held high: BP then non-BP
    for (int m = 1; m >= 0; m--) begin
      bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.mode_BP = m[0];
      bus.use2x2 = 4'b0110; bus.suffix = rnd_sfx();
      last = -1; nacc = 0;
      for (int i = 0; i < 20; i++) begin
        if (bus.in_ready) begin
          if (last >= 0)
            chk("throughput_gap", 256'(cyc + 1 - last), 256'((m != 0) ? NP + 2 : 2));
          last = cyc + 1; nacc++;
        end
        step();
      end
      bus.in_valid = 1'b0;
      chk("throughput_count", 256'(nacc >= 3), 256'(1));
      repeat (NP + 3) step();
      bus.out_ready = 1'b0;
      chk("drain_idle", 256'(bus.in_ready), 256'(1));
    end

    chk("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
